bus32_arb: RTL and testbench

BUS32_ARB -- requirements
Module: bus32_arb

---
 rtl/bus32_pkg.sv | 22 ++
 rtl/bus32_arb_rr_pick.sv | 44 ++++
 rtl/bus32_arb.sv | 101 ++++++++++
 tb/tb_bus32_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bus32_pkg.sv
// Shared definitions for the 32-bit tri-state bus arbiter: FSM encodings,
// default source count and index width.
package bus32_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   localparam int N_DEFAULT = 8;
   localparam int IDX_W     = 4;

   // Round-robin successor of a source index for an n-source bus.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
      if (int'(i) >= n - 1) begin
         return '0;
      end
      return i + 4'd1;
   endfunction

endpackage

// File: rtl/bus32_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index at or above ptr,
// otherwise the lowest requesting index overall.
module rr_pick
   import bus32_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             hit,
   output logic [IDX_W-1:0] index
);

   logic [N-1:0] upper_mask;
   logic [N-1:0] upper_req;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_mask
         assign upper_mask[gi] = (IDX_W'(gi) >= ptr);
      end
   endgenerate

   assign upper_req = req & upper_mask;

   // Descending scans leave the lowest set index; the upper half wins when non-empty.
   always_comb begin
      hit   = |req;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            index = IDX_W'(i);
         end
      end
      if (|upper_req) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
               index = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/bus32_arb.sv
// Round-robin arbiter for an N-source 32-bit tri-state bus: drives the
// active-low buffer enables, samples the resolved bus and acks the source.
module bus32_arb
   import bus32_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [31:0]      y,
   output logic [N-1:0]     g,
   output logic [N-1:0]     ack,
   output logic [31:0]      q,
   output logic             q_valid,
   output logic [IDX_W-1:0] q_src
);

   state_t           state_reg;
   logic [IDX_W-1:0] k_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [N-1:0]     g_reg;
   logic [N-1:0]     ack_reg;
   logic [31:0]      q_reg;
   logic             q_valid_reg;
   logic [IDX_W-1:0] q_src_reg;

   logic             pick_hit;
   logic [IDX_W-1:0] pick_idx;
   logic [N-1:0]     pick_oh;
   logic [N-1:0]     k_oh;

   rr_pick #(
      .N(N)
   ) u_rr_pick (
      .req  (req),
      .ptr  (ptr_reg),
      .hit  (pick_hit),
      .index(pick_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign pick_oh[gi] = (pick_idx == IDX_W'(gi));
         assign k_oh[gi]    = (k_reg == IDX_W'(gi));
      end
   endgenerate

   // g and ack are registered alongside the state so req/y never reach them combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         k_reg       <= '0;
         ptr_reg     <= '0;
         g_reg       <= '1;
         ack_reg     <= '0;
         q_reg       <= '0;
         q_valid_reg <= 1'b0;
         q_src_reg   <= '0;
      end else begin
         q_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               g_reg   <= '1;
               ack_reg <= '0;
               if (pick_hit) begin
                  k_reg     <= pick_idx;
                  g_reg     <= ~pick_oh;
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               ack_reg   <= k_oh;
               state_reg <= SAMPLE;
            end
            SAMPLE: begin
               q_reg       <= y;
               q_src_reg   <= k_reg;
               q_valid_reg <= 1'b1;
               ptr_reg     <= wrap_inc(k_reg, N);
               g_reg       <= '1;
               ack_reg     <= '0;
               state_reg   <= IDLE;
            end
            default: begin
               g_reg     <= '1;
               ack_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign g       = g_reg;
   assign ack     = ack_reg;
   assign q       = q_reg;
   assign q_valid = q_valid_reg;
   assign q_src   = q_src_reg;

endmodule

// File: tb/tb_bus32_arb.sv
// Directed bench for bus32_arb with a behavioural model of the buffer bank
// resolving y from the active-low enables.
module tb_bus32_arb;
   import bus32_pkg::*;

   localparam int N = N_DEFAULT;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req;
   logic [31:0]      y;
   logic [N-1:0]     g;
   logic [N-1:0]     ack;
   logic [31:0]      q;
   logic             q_valid;
   logic [IDX_W-1:0] q_src;

   logic [31:0]  src_data [N];
   logic [N-1:0] all_hi;
   logic [N-1:0] prev_g;
   logic         mon_en;
   int           n_checks;
   int           n_pass;

   bus32_arb #(
      .N(N)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .y      (y),
      .g      (g),
      .ack    (ack),
      .q      (q),
      .q_valid(q_valid),
      .q_src  (q_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      y = '0;
      for (int i = 0; i < N; i++) begin
         if (!g[i]) begin
            y = src_data[i];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // At most one enable low, and never a direct hand-over between two sources.
   always @(negedge clk) begin
      if (mon_en) begin
         check("g_onecold", 32'($countones(~g) <= 1), 32'd1);
         check("g_bbm", 32'(prev_g == all_hi || g == all_hi || g == prev_g), 32'd1);
         prev_g <= g;
      end
   end

   task automatic grant(input int s, input bit drop_in_drive, input bit release_on_ack);
      int           waited;
      logic [N-1:0] oh;
      logic [N-1:0] exp_g;
      waited = 0;
      oh     = '0;
      oh[s]  = 1'b1;
      exp_g  = ~oh;
      while (g == all_hi && waited < 20) begin
         tick(1);
         waited++;
      end
      check("grant_latency", waited, 1);
      check("drive_g", g, exp_g);
      check("drive_ack", ack, 0);
      if (drop_in_drive) req[s] = 1'b0;
      tick(1);
      check("sample_g", g, exp_g);
      check("sample_ack", ack, oh);
      if (release_on_ack) req[s] = 1'b0;
      tick(1);
      check("q_valid", q_valid, 1);
      check("q", q, src_data[s]);
      check("q_src", q_src, s);
      check("idle_g", g, all_hi);
      check("idle_ack", ack, 0);
      $display("xfer src=%0d q=%08h q_valid=%0d", q_src, q, q_valid);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      all_hi   = '1;
      prev_g   = '1;
      for (int i = 0; i < N; i++) begin
         src_data[i] = 32'h1000_0000 + 32'h0101_0011 * i;
      end
      src_data[2] = 32'hDEAD_BEEF;
      rst = 1'b1;
      req = '0;

      // Reset state
      tick(2);
      mon_en = 1'b1;
      check("rst_g", g, all_hi);
      check("rst_ack", ack, 0);
      check("rst_q", q, 0);
      check("rst_q_valid", q_valid, 0);
      check("rst_q_src", q_src, 0);
      rst = 1'b0;
      tick(3);
      check("idle_quiet_g", g, all_hi);
      check("idle_quiet_qv", q_valid, 0);

      // Single request from source 2
      req = 8'h04;
      grant(2, 1'b0, 1'b1);
      tick(1);
      check("single_qv_pulse", q_valid, 0);
      check("single_q_hold", q, 32'hDEAD_BEEF);
      check("single_g_idle", g, all_hi);

      // Fairness with all sources requesting continuously
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      req = '1;
      for (int i = 0; i < N; i++) begin
         grant(i, 1'b0, 1'b0);
      end
      grant(0, 1'b0, 1'b0);
      req = '0;
      tick(1);

      // Pointer wrap: grant 6, then 7 ahead of 0
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      req = 8'h40;
      grant(6, 1'b0, 1'b1);
      req = 8'h81;
      grant(7, 1'b0, 1'b1);
      grant(0, 1'b0, 1'b1);

      // Reset during SAMPLE abandons the transfer and clears ptr
      req = 8'h02;
      tick(1);
      check("mrst_drive_g", g, 8'hFD);
      tick(1);
      check("mrst_sample_ack", ack, 8'h02);
      rst = 1'b1;
      req = '0;
      tick(1);
      check("mrst_q_valid", q_valid, 0);
      check("mrst_q", q, 0);
      check("mrst_q_src", q_src, 0);
      check("mrst_g", g, all_hi);
      check("mrst_ack", ack, 0);
      rst = 1'b0;
      req = 8'h81;
      grant(0, 1'b0, 1'b1);
      grant(7, 1'b0, 1'b1);

      // Request dropped during DRIVE still completes
      req = 8'h10;
      grant(4, 1'b1, 1'b1);
      tick(3);
      check("drop_g_idle", g, all_hi);
      check("drop_qv_low", q_valid, 0);
      check("drop_q_src_hold", q_src, 4);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
